mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES SHALL be: TIMEOUT_CYCLES, 64, max ACCESS cycles without dmem_ack before bus_error (legal range 2..1024).
REQ-002 Ports SHALL be, in order (name  direction  width  meaning):
 clock  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-low reset
 flush  in  1  squash: block acceptance, discard in-flight result
 in_valid  in  1  EX-stage bundle valid
 in_ready  out  1  unit accepts bundle this cycle; upstream freezes when low
 ex_out  in  64  ALU result / effective address
 ex_B_data  in  64  store data
 ex_load_type  in  2  0 none, 1 byte, 2 word, 3 dword
 ex_store_type  in  2  0 none, 1 byte, 2 word, 3 dword
 ex_signed_byte, ex_signed_word  in  1 each  sign-extend byte/word loads
 ex_W_regnum  in  5  destination register
 ex_write_enable  in  1  register write request
 dmem_req  out  1  bus request
 dmem_we  out  1  bus write
 dmem_addr  out  64  dword-aligned address ([2:0]=0)
 dmem_wdata  out  64  store data, lane-replicated
 dmem_wstrb  out  8  byte enables, bit i = byte i
 dmem_ack  in  1  bus completion, 1-cycle pulse
 dmem_rdata  in  64  load data, valid with dmem_ack
 wb_valid  out  1  write-back bundle valid, 1-cycle pulse
 wb_W_data  out  64  write-back data
 wb_W_regnum  out  5  write-back register
 wb_write_enable  out  1  register write
 addr_error  out  1  misaligned access, 1-cycle pulse
 bus_error  out  1  bus timeout, 1-cycle pulse
 bad_vaddr  out  64  faulting address, held until next fault

Function
REQ-003 FSM SHALL have states IDLE, ACCESS; in_ready = (state==IDLE) & ~flush; accept = in_valid & in_ready.
REQ-004 Memory op SHALL be store_type!=0 or load_type!=0; store_type!=0 SHALL take priority, load_type ignored, no register write.
REQ-005 Non-memory accept in cycle N SHALL give wb_valid=1 in N+1 with wb_W_data=ex_out, regnum/write_enable copied; back-to-back 1/cycle.
REQ-006 Alignment: word SHALL need ex_out[1:0]==0, dword ex_out[2:0]==0; misaligned accept in N SHALL give addr_error=1, bad_vaddr=ex_out, wb_valid=0 in N+1, no bus activity, state stays IDLE.
REQ-007 Aligned memory accept SHALL enter ACCESS; dmem_req SHALL be 1 from N+1 through ack cycle M inclusive, bus outputs stable throughout.
REQ-008 dmem_addr SHALL be {ex_out[63:3],3'b0}; lanes little-endian: byte lane ex_out[2:0], word lanes 4*ex_out[2].
REQ-009 Stores: dmem_we=1; wdata SHALL replicate byte x8 / word x2 / dword; wstrb one bit / 4'hF at word lane / 8'hFF; wb_valid=1, wb_write_enable=0 in M+1.
REQ-010 Loads: dmem_we=0, wstrb=0; selected lane SHALL be sign-extended when signed flag set, else zero-extended; dword unmodified; wb in M+1.
REQ-011 State SHALL return to IDLE in M+1; in_ready high in M+1.
REQ-012 Cycle counter SHALL clear on ACCESS entry; if TIMEOUT_CYCLES ACCESS cycles pass without ack, SHALL drop dmem_req, pulse bus_error, set bad_vaddr=address, go IDLE, wb_valid=0.
REQ-013 flush in IDLE SHALL block acceptance; flush during ACCESS SHALL NOT abort bus request but SHALL suppress wb_valid and bus_error of that op.
REQ-014 dmem_ack outside ACCESS SHALL be ignored.

Reset
REQ-015 reset low SHALL immediately force state IDLE, counter 0, all outputs 0 except in_ready (1 when flush low); dmem_req SHALL drop asynchronously mid-access.

Verification
REQ-016 ALU op ex_out=0x1234, regnum 5, we=1 -> next cycle wb_valid=1, W_data=0x1234, regnum 5.
REQ-017 Signed byte load addr 0x103, ack after 3 cycles with rdata byte3=0x80 -> dmem_addr 0x100, W_data=0xFFFFFFFFFFFFFF80 in ack+1.
REQ-018 Word store addr 0x204, B_data=0xAABBCCDD -> wdata=0xAABBCCDDAABBCCDD, wstrb=0xF0, wb_write_enable=0.
REQ-019 Dword load addr 0x104 -> addr_error pulse, bad_vaddr=0x104, dmem_req never asserted.
REQ-020 No ack for 64 ACCESS cycles -> bus_error pulse, dmem_req low, in_ready high next cycle; repeat with flush mid-access -> no bus_error/wb_valid.
REQ-021 reset low during ACCESS -> dmem_req 0 same cycle, state IDLE, no wb_valid after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory stage: passes ALU results to write-back or performs one aligned load/store
// on a request/ack data bus, with misalignment and bus-timeout fault reporting.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] ex_out,
    input  logic [63:0] ex_B_data,
    input  logic [1:0]  ex_load_type,
    input  logic [1:0]  ex_store_type,
    input  logic        ex_signed_byte,
    input  logic        ex_signed_word,
    input  logic [4:0]  ex_W_regnum,
    input  logic        ex_write_enable,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        wb_valid,
    output logic [63:0] wb_W_data,
    output logic [4:0]  wb_W_regnum,
    output logic        wb_write_enable,
    output logic        addr_error,
    output logic        bus_error,
    output logic [63:0] bad_vaddr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              flushed_q;
    logic [1:0]        ld_type_q;
    logic [2:0]        ld_off_q;
    logic              ld_sb_q;
    logic              ld_sw_q;
    logic [4:0]        pend_regnum_q;
    logic              pend_we_q;

    logic              dmem_req_q;
    logic              dmem_we_q;
    logic [63:0]       dmem_addr_q;
    logic [63:0]       dmem_wdata_q;
    logic [7:0]        dmem_wstrb_q;
    logic              wb_valid_q;
    logic [63:0]       wb_W_data_q;
    logic [4:0]        wb_W_regnum_q;
    logic              wb_write_enable_q;
    logic              addr_error_q;
    logic              bus_error_q;
    logic [63:0]       bad_vaddr_q;

    logic              accept_s;
    logic              is_store_s;
    logic              is_mem_s;
    logic              misaligned_s;
    logic [1:0]        size_s;

    function automatic logic [63:0] store_data(input logic [1:0] st, input logic [63:0] b);
        logic [63:0] r;
        case (st)
            2'd1:    r = {8{b[7:0]}};
            2'd2:    r = {2{b[31:0]}};
            2'd3:    r = b;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] store_strb(input logic [1:0] st, input logic [2:0] off);
        logic [7:0] r;
        case (st)
            2'd1:    r = 8'b0000_0001 << off;
            2'd2:    r = off[2] ? 8'hF0 : 8'h0F;
            2'd3:    r = 8'hFF;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Little-endian lane extraction with optional sign extension.
    function automatic logic [63:0] load_extend(input logic [63:0] rd, input logic [1:0] lt,
                                                input logic [2:0] off, input logic sb,
                                                input logic sw);
        logic [7:0]  b;
        logic [31:0] w;
        logic [63:0] r;
        b = rd[{off, 3'b000} +: 8];
        w = off[2] ? rd[63:32] : rd[31:0];
        case (lt)
            2'd1:    r = sb ? {{56{b[7]}}, b} : {56'd0, b};
            2'd2:    r = sw ? {{32{w[31]}}, w} : {32'd0, w};
            2'd3:    r = rd;
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    assign in_ready = (state_q == IDLE) & ~flush;
    assign accept_s = in_valid & in_ready;

    // Decode the incoming bundle: store wins over load, alignment per access size.
    always_comb begin
        is_store_s   = (ex_store_type != 2'd0);
        is_mem_s     = is_store_s | (ex_load_type != 2'd0);
        size_s       = 2'd0;
        misaligned_s = 1'b0;
        if (is_store_s) begin
            size_s = ex_store_type;
        end else begin
            size_s = ex_load_type;
        end
        case (size_s)
            2'd2:    misaligned_s = (ex_out[1:0] != 2'b00);
            2'd3:    misaligned_s = (ex_out[2:0] != 3'b000);
            default: misaligned_s = 1'b0;
        endcase
    end

    // Control FSM with all outputs registered; pulses default low each cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            flushed_q         <= 1'b0;
            ld_type_q         <= 2'd0;
            ld_off_q          <= 3'd0;
            ld_sb_q           <= 1'b0;
            ld_sw_q           <= 1'b0;
            pend_regnum_q     <= 5'd0;
            pend_we_q         <= 1'b0;
            dmem_req_q        <= 1'b0;
            dmem_we_q         <= 1'b0;
            dmem_addr_q       <= 64'd0;
            dmem_wdata_q      <= 64'd0;
            dmem_wstrb_q      <= 8'd0;
            wb_valid_q        <= 1'b0;
            wb_W_data_q       <= 64'd0;
            wb_W_regnum_q     <= 5'd0;
            wb_write_enable_q <= 1'b0;
            addr_error_q      <= 1'b0;
            bus_error_q       <= 1'b0;
            bad_vaddr_q       <= 64'd0;
        end else begin
            wb_valid_q   <= 1'b0;
            addr_error_q <= 1'b0;
            bus_error_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s && !is_mem_s) begin
                        wb_valid_q        <= 1'b1;
                        wb_W_data_q       <= ex_out;
                        wb_W_regnum_q     <= ex_W_regnum;
                        wb_write_enable_q <= ex_write_enable;
                    end else if (accept_s && misaligned_s) begin
                        addr_error_q <= 1'b1;
                        bad_vaddr_q  <= ex_out;
                    end else if (accept_s) begin
                        state_q       <= ACCESS;
                        cnt_q         <= '0;
                        flushed_q     <= 1'b0;
                        dmem_req_q    <= 1'b1;
                        dmem_we_q     <= is_store_s;
                        dmem_addr_q   <= {ex_out[63:3], 3'b000};
                        dmem_wdata_q  <= is_store_s ? store_data(ex_store_type, ex_B_data) : 64'd0;
                        dmem_wstrb_q  <= is_store_s ? store_strb(ex_store_type, ex_out[2:0]) : 8'd0;
                        ld_type_q     <= is_store_s ? 2'd0 : ex_load_type;
                        ld_off_q      <= ex_out[2:0];
                        ld_sb_q       <= ex_signed_byte;
                        ld_sw_q       <= ex_signed_word;
                        pend_regnum_q <= ex_W_regnum;
                        pend_we_q     <= is_store_s ? 1'b0 : ex_write_enable;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ACCESS: begin
                    flushed_q <= flushed_q | flush;
                    if (dmem_ack) begin
                        state_q           <= IDLE;
                        dmem_req_q        <= 1'b0;
                        dmem_we_q         <= 1'b0;
                        dmem_wstrb_q      <= 8'd0;
                        wb_valid_q        <= ~(flushed_q | flush);
                        wb_W_data_q       <= load_extend(dmem_rdata, ld_type_q, ld_off_q,
                                                         ld_sb_q, ld_sw_q);
                        wb_W_regnum_q     <= pend_regnum_q;
                        wb_write_enable_q <= pend_we_q;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= IDLE;
                        dmem_req_q   <= 1'b0;
                        dmem_we_q    <= 1'b0;
                        dmem_wstrb_q <= 8'd0;
                        bus_error_q  <= ~(flushed_q | flush);
                        bad_vaddr_q  <= dmem_addr_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmem_req        = dmem_req_q;
    assign dmem_we         = dmem_we_q;
    assign dmem_addr       = dmem_addr_q;
    assign dmem_wdata      = dmem_wdata_q;
    assign dmem_wstrb      = dmem_wstrb_q;
    assign wb_valid        = wb_valid_q;
    assign wb_W_data       = wb_W_data_q;
    assign wb_W_regnum     = wb_W_regnum_q;
    assign wb_write_enable = wb_write_enable_q;
    assign addr_error      = addr_error_q;
    assign bus_error       = bus_error_q;
    assign bad_vaddr       = bad_vaddr_q;

endmodule
